// File: rtl/irq_pending_arbiter.sv
// Pending-interrupt arbiter: captures requests into a pending register, grants the
// highest-priority unmasked one and holds it until ack. IRQ_EDGE_DETECT_EN selects edge capture.
module irq_pending_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] idx,
  output logic [7:0] pending,
  output logic [7:0] mask
);

  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

  state_t     state, state_nxt;
  logic [7:0] capture;
  logic [7:0] eligible;
  logic [7:0] clr;
  logic [2:0] hi_idx;
  logic [2:0] idx_nxt;

`ifdef IRQ_EDGE_DETECT_EN
  logic [7:0] req_d;

  always_ff @(posedge clk) begin
    if (rst) req_d <= '0;
    else     req_d <= req;
  end

  assign capture = req & ~req_d;
`else
  assign capture = req;
`endif

  assign eligible = pending & mask;
  assign valid    = (state == GRANT);

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (eligible[i]) hi_idx = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr       = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = GRANT;
          idx_nxt   = hi_idx;
        end
      end
      GRANT: begin
        if (ack) begin
          clr       = 8'b1 << idx;
          state_nxt = CLEAR;
        end
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      // Capture is OR-ed after the clear so a coincident set survives the ack.
      pending <= (pending & ~clr) | capture;
      if (mask_wr) mask <= mask_in;
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Scoreboard bench for irq_pending_arbiter: a rule-level model predicts grants into a
// queue; a monitor pops on each new grant and checks pending/mask/valid every cycle.
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_in = '0;
  logic       ack = 1'b0;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] pending;
  logic [7:0] mask;

  irq_pending_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask_wr (mask_wr),
    .mask_in (mask_in),
    .ack     (ack),
    .valid   (valid),
    .idx     (idx),
    .pending (pending),
    .mask    (mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit en = 1'b0;

  // Reference model state (value expected after the upcoming edge)
  bit [7:0] m_pending = '0;
  bit [7:0] m_mask    = 8'hFF;
  bit [7:0] m_req_d   = '0;
  bit       m_valid   = 1'b0;
  bit       m_cool    = 1'b0;
  bit [2:0] m_idx     = '0;
  bit       m_rst_seen = 1'b0;
  bit [2:0] exp_q[$];

  logic [2:0] held = '0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit [2:0] highest(input bit [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic model_step();
    bit [7:0] cap;
    bit [7:0] clr;
    bit [7:0] elig;
`ifdef IRQ_EDGE_DETECT_EN
    cap = req & ~m_req_d;
`else
    cap = req;
`endif
    if (rst) begin
      m_pending = '0; m_mask = 8'hFF; m_req_d = '0;
      m_valid = 1'b0; m_cool = 1'b0; m_idx = '0; m_rst_seen = 1'b1;
      return;
    end
    m_rst_seen = 1'b0;
    clr  = '0;
    elig = m_pending & m_mask;
    if (m_valid) begin
      if (ack) begin
        clr[m_idx] = 1'b1;
        m_valid = 1'b0;
        m_cool  = 1'b1;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (elig != 0) begin
      m_idx   = highest(elig);
      m_valid = 1'b1;
      exp_q.push_back(m_idx);
    end
    m_pending = (m_pending & ~clr) | cap;
    if (mask_wr) m_mask = mask_in;
    m_req_d = req;
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq, input logic mw,
                     input logic [7:0] mi, input logic a);
    @(negedge clk);
    rst = r; req = rq; mask_wr = mw; mask_in = mi; ack = a;
    model_step();
    en = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, m_valid);
  endtask

  always @(posedge clk) begin
    #1;
    if (en) begin
      chk("valid", valid, m_valid);
      chk("pending", pending, m_pending);
      chk("mask", mask, m_mask);
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("grant_queue", 0, 1);
        end else begin
          held = exp_q.pop_front();
          chk("grant_idx", idx, held);
        end
      end else if (valid) begin
        chk("idx_hold", idx, held);
      end else if (m_rst_seen) begin
        chk("reset_idx", idx, 0);
      end
      prev_valid = valid;
    end
  end

  initial begin
    // Single request after reset
    cyc(1, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h80, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 1);
    drain(3);

    // Priority with higher request arriving during the grant
    cyc(0, 8'h12, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'hFF, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    drain(30);

    // Masking
    cyc(0, 8'h00, 1, 8'h0F, 0);
    cyc(0, 8'hF0, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 1);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h00, 1, 8'hFF, 0);
    drain(20);

    // Held request with repeated acks
    for (int i = 0; i < 15; i++) cyc(0, 8'h01, 0, 8'h00, m_valid);
    drain(6);

    // Set-wins: fresh pulse on granted bit coincident with ack
    cyc(0, 8'h10, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h10, 0, 8'h00, 1);
    cyc(0, 8'h00, 0, 8'h00, 0);
    drain(8);

    // Reset during a grant, with a request held across reset release
    cyc(0, 8'h04, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(1, 8'h20, 1, 8'h00, 1);
    cyc(0, 8'h20, 0, 8'h00, 0);
    cyc(0, 8'h20, 0, 8'h00, 0);
    drain(8);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic       r;
      logic [7:0] rq;
      logic       mw;
      logic       a;
      r  = ($urandom_range(0, 99) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mw = ($urandom_range(0, 9) == 0);
      a  = m_valid ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      cyc(r, rq, mw, 8'($urandom), a);
    end

    cyc(0, 8'h00, 1, 8'hFF, m_valid);
    drain(40);
    @(posedge clk);
    #2;
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_pending_arbiter.md
IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

Interface
REQ-001 Clock and reset: clk input 1 is the single clock; all state updates on its rising edge.
REQ-002 Reset: rst input 1 is synchronous and active-high.
REQ-003 Requests: req input 8 carries the request lines; bit 7 is highest priority and bit 0 lowest, matching the downstream 8-to-3 encoder ordering.
REQ-004 Mask load: mask_wr input 1 loads mask_in into the mask register when high.
REQ-005 Mask data: mask_in input 8; bit value 1 enables the corresponding request.
REQ-006 Acknowledge: ack input 1 signals that the consumer accepts the presented grant.
REQ-007 Grant valid: valid output 1 is high while a grant is presented.
REQ-008 Grant index: idx output 3 is the index of the granted request, meaningful only when valid=1.
REQ-009 Pending: pending output 8 mirrors the pending register.
REQ-010 Mask: mask output 8 mirrors the mask register.

Function
REQ-011 Capture: pending[k] SHALL set on any cycle where capture_k=1; pending bits are never cleared by req deasserting.
REQ-012 Eligibility: eligible = pending & mask; masked bits SHALL stay pending but SHALL never be granted.
REQ-013 State machine states: IDLE, GRANT, CLEAR; encoding is free.
REQ-014 IDLE: if eligible≠0, SHALL go to GRANT next edge, with idx = highest set eligible bit and valid=1.
REQ-015 IDLE with nothing eligible: if eligible=0, SHALL stay in IDLE with valid=0.
REQ-016 Latency: a request sampled at edge N sets pending at edge N and drives valid=1 at edge N+1 when starting from IDLE.
REQ-017 GRANT hold: idx and valid SHALL hold stable until ack=1, even if a higher-priority request arrives or mask changes meanwhile.
REQ-018 Acknowledge: GRANT with ack=1 SHALL clear pending[idx], drop valid, and go to CLEAR at the next edge.
REQ-019 Set-wins: if a capture on bit idx coincides with its ack clear, the set SHALL win and the bit stays pending.
REQ-020 CLEAR: SHALL last exactly one cycle with valid=0, then return to IDLE for re-arbitration; back-to-back grants are therefore separated by at least two cycles.
REQ-021 Stray ack: ack while valid=0 SHALL be ignored.
REQ-022 Mask timing: mask_wr takes effect at the next edge and is independent of arbitration state.

Reset
REQ-023 On rst=1 at a rising edge: pending=0, mask=8'hFF, valid=0, idx=0, state=IDLE.
REQ-024 Reset priority: rst SHALL override all other inputs in the same cycle, including mid-GRANT; any presented grant is abandoned.
REQ-025 Post-reset: requests held across reset deassertion SHALL be captured on the first edge after rst=0.

Configuration
REQ-026 With IRQ_EDGE_DETECT_EN defined: capture_k = req[k] & ~req_d[k], where req_d is req registered one cycle and reset to 0; a held-high line pends once only.
REQ-027 Without IRQ_EDGE_DETECT_EN: capture_k = req[k] (level); a held-high line re-pends immediately after each ack.

Verification
REQ-028 Reset: reset, then req=8'h80 for one cycle -> valid=1, idx=3'b111 one edge after capture; pending=8'h80.
REQ-029 Priority and hold: req=8'h12 together, then req=8'hFF while in GRANT -> idx=4 held until ack; after ack and CLEAR, next grant idx=7.
REQ-030 Masking: mask_in=8'h0F with mask_wr=1, then req=8'hF0 -> valid stays 0 and pending=8'hF0; then write mask 8'hFF -> grant idx=7.
REQ-031 Held request: req held at 8'h01 with repeated acks -> level build re-grants idx=0 every 3 cycles; IRQ_EDGE_DETECT_EN build grants once only.
REQ-032 Set-wins and reset: new pulse on bit idx coincident with ack -> pending bit remains 1; rst asserted during GRANT -> all outputs at reset values the next edge.
